// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexed 7-segment display driver. The module lights one digit at a time
// and steps through all N_DIGITS digits in turn. It adds:
//   - brightness PWM,
//   - leading-zero suppression,
//   - per-digit blank, blink and decimal point,
//   - a 2-cycle anti-ghost dead time at the start of every digit.
// All inputs are snapshotted once per frame, so one frame always shows one
// consistent set of inputs.
//
// Ports:
//   CLK100      system clock
//   RST         asynchronous active-high reset
//   digits      4-bit hex code per digit, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp          decimal point request per digit
//   blank       force a digit dark
//   blink       digit dark while blink_phase is 1
//   lz_en       leading-zero suppression enable
//   bright      PWM duty = (bright+1)/8 of each digit period
//   AN          anode enables (polarity set by AN_ACTIVE_LOW)
//   SEG         {g,f,e,d,c,b,a}, active low
//   DP          decimal point, active low
//   frame_done  one-cycle pulse after the last digit period of a frame ends
module seg_scan_driver #(
    parameter int N_DIGITS      = 8,
    parameter int CLK_HZ        = 100_000_000,
    parameter int SCAN_HZ       = 8000,
    parameter int BLINK_HZ      = 2,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK100,
    input  logic                    RST,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic [N_DIGITS-1:0]     blink,
    input  logic                    lz_en,
    input  logic [2:0]              bright,
    output logic [N_DIGITS-1:0]     AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic                    frame_done
);

    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int SLOT_LEN  = DIV / 8;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int PH_W      = $clog2(DIV);
    localparam int SUB_W     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int IDX_W     = $clog2(N_DIGITS);
    localparam int BL_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [N_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // The slot counter only works if each digit period splits into eight
    // equal slots that are long enough to hold the dead time.
    generate
        if ((DIV % 8) != 0 || DIV < 32) begin : g_bad_div
            $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be a multiple of 8 and at least 32");
        end
        if (N_DIGITS < 2 || N_DIGITS > 16) begin : g_bad_digits
            $error("seg_scan_driver: N_DIGITS must be in 2..16");
        end
    endgenerate

    logic [PH_W-1:0]         phase_q, phase_d;
    logic [SUB_W-1:0]        sub_q, sub_d;
    logic [2:0]              slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic [4*N_DIGITS-1:0]   sh_digits_q, sh_digits_d;
    logic [N_DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [N_DIGITS-1:0]     sh_blank_q, sh_blank_d;
    logic [N_DIGITS-1:0]     sh_blink_q, sh_blink_d;
    logic                    sh_lz_q, sh_lz_d;
    logic [2:0]              sh_bright_q, sh_bright_d;

    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    phase_wrap;
    logic                    frame_wrap;
    logic                    snap;
    logic                    zero_run;
    logic [N_DIGITS-1:0]     suppress;
    logic [3:0]              cur_code;
    logic                    lit;
    logic [N_DIGITS-1:0]     onehot;

    // Scan timing: phase within the digit period, slot (phase / SLOT_LEN) kept
    // as its own counter so no divider is needed, and the digit index.
    always_comb begin
        phase_wrap = (phase_q == PH_W'(DIV - 1));
        frame_wrap = phase_wrap && (idx_q == IDX_W'(N_DIGITS - 1));

        phase_d = phase_wrap ? '0 : phase_q + PH_W'(1);

        sub_d  = sub_q + SUB_W'(1);
        slot_d = slot_q;
        if (phase_wrap) begin
            sub_d  = '0;
            slot_d = 3'd0;
        end else if (sub_q == SUB_W'(SLOT_LEN - 1)) begin
            sub_d  = '0;
            slot_d = slot_q + 3'd1;
        end

        idx_d = idx_q;
        if (phase_wrap) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        frame_done_d = frame_wrap;
    end

    // The blink timebase runs freely and ignores the scan.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BL_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Shadow capture happens on the first cycle of every frame (index 0,
    // phase 0). This covers both the wrap back to digit 0 and the first cycle
    // after reset release. The dead time keeps phase 0 dark, so the previous
    // frame's shadow is never shown with the new index.
    always_comb begin
        snap        = (idx_q == '0) && (phase_q == '0);
        sh_digits_d = snap ? digits : sh_digits_q;
        sh_dp_d     = snap ? dp     : sh_dp_q;
        sh_blank_d  = snap ? blank  : sh_blank_q;
        sh_blink_d  = snap ? blink  : sh_blink_q;
        sh_lz_d     = snap ? lz_en  : sh_lz_q;
        sh_bright_d = snap ? bright : sh_bright_q;
    end

    // Leading-zero suppression. A running "everything above is zero" flag
    // walks down from the most significant digit. Digit 0 is always shown.
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (sh_digits_q[4*i +: 4] == 4'h0);
            suppress[i] = sh_lz_q & zero_run;
        end
    end

    // Lit decision for the current digit, plus the registered pin values.
    always_comb begin
        cur_code = sh_digits_q[{idx_q, 2'b00} +: 4];
        lit = !sh_blank_q[idx_q]
              && !suppress[idx_q]
              && !(sh_blink_q[idx_q] && blink_phase_q)
              && (slot_q <= sh_bright_q)
              && (phase_q >= PH_W'(2));

        onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;

        an_d  = AN_OFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
            dp_d = ~sh_dp_q[idx_q];
            case (cur_code)
                4'h0: seg_d = 7'h40;
                4'h1: seg_d = 7'h79;
                4'h2: seg_d = 7'h24;
                4'h3: seg_d = 7'h30;
                4'h4: seg_d = 7'h19;
                4'h5: seg_d = 7'h12;
                4'h6: seg_d = 7'h02;
                4'h7: seg_d = 7'h78;
                4'h8: seg_d = 7'h00;
                4'h9: seg_d = 7'h10;
                4'hA: seg_d = 7'h08;
                4'hB: seg_d = 7'h03;
                4'hC: seg_d = 7'h46;
                4'hD: seg_d = 7'h21;
                4'hE: seg_d = 7'h06;
                default: seg_d = 7'h0E;
            endcase
        end
    end

    // All state and pins are registered, so the pins show the previous
    // cycle's counter state.
    always_ff @(posedge CLK100 or posedge RST) begin
        if (RST) begin
            phase_q       <= '0;
            sub_q         <= '0;
            slot_q        <= 3'd0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_blink_q    <= '0;
            sh_lz_q       <= 1'b0;
            sh_bright_q   <= 3'd0;
            an_q          <= AN_OFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            sub_q         <= sub_d;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            sh_lz_q       <= sh_lz_d;
            sh_bright_q   <= sh_bright_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign frame_done = frame_done_q;

endmodule
